branch_target_unit: RTL and testbench
=====================================

// Module: branch_target_unit
// PURPOSE
//  Pipelined branch/jump target generator for the MIPS front end; replaces the fixed combinational immediate shift.
//  Takes PC, sign-extended immediate, jump index and rs value, and returns the redirect target plus the fall-through PC.
//  Valid/ready handshake on both sides, with depth-parametrised pipelining.
//  Sits between ID operand read and the fetch redirect mux.
// PARAMETERS
//  DATA_W      32  address/data width (matches `DATALENGTH)
//  SHIFT       2   immediate/index left shift (log2 instruction bytes)
//  PIPE_STAGES 2   register stages, legal 1 or 2; equals latency in cycles
// PORTS
//  clock           in   1          single clock, rising edge
//  reset           in   1          synchronous, active-high
//  flush           in   1          discard all in-flight and same-cycle input
//  in_valid        in   1          request valid
//  in_ready        out  1          unit can accept this cycle
//  in_mode         in   2          `BTU_BR=00, `BTU_J=01, `BTU_JR=10, 11 reserved
//  in_pc           in   DATA_W     PC of branch instruction
//  in_imm          in   DATA_W     sign-extended 16-bit offset
//  in_index        in   DATA_W-6   J/JAL instr_index field
//  in_rs           in   DATA_W     rs register value (JR/JALR)
//  out_valid       out  1          result valid
//  out_ready       in   1          consumer accepts
//  out_target      out  DATA_W     computed redirect target
//  out_fallthrough out  DATA_W     in_pc + 4 (link / not-taken PC)
//  out_addr_exc    out  1          present only with BTU_ADDR_EXC_EN
// BEHAVIOUR
//  - Reset: all stage valids 0. out_valid=0. out_target/out_fallthrough=0. out_addr_exc=0. in_ready=1 from the cycle after reset.
//  - Transfers: input on in_valid&in_ready; output on out_valid&out_ready. No combinational path from in_valid to out_*.
//  - Stage advance: stage k loads when it is empty, or when its downstream stage loads/drains this cycle.
//  - in_ready = ~stage1_valid | stage1_advances. It depends on out_ready combinationally; there is no skid buffer.
//  - Stage 1 (always present) registers: mode, fall = pc+4, off = imm<<SHIFT, the jump region {fall[DATA_W-1:DATA_W-4], index, SHIFT'b0}, and rs.
//  - Final stage selects the target:
//      BR  : fall + off
//      J   : region
//      JR  : rs
//      11  : fall
//  - When PIPE_STAGES=1, selection is combinational from the stage-1 registers.
//  - Latency: PIPE_STAGES cycles from accept to out_valid when the pipeline is unstalled. Throughput 1/cycle.
//  - Arithmetic: modulo 2^DATA_W; carries out of the MSB are dropped (wrap-around is legal, no flag).
//  - Stall: while out_valid&~out_ready, out_* hold stable and no stage overwrites an unconsumed entry.
//  - Flush: all valids clear on the next edge, and the same-cycle input is dropped.
//      Flush wins over simultaneous accept and drain; out_valid=0 in the following cycle.
//  - Reset mid-operation: identical to flush, and data registers also return to 0.
//  - Full: with PIPE_STAGES entries held and out_ready=0, in_ready=0.
//  - Simultaneous full + drain: in_ready=1 and one entry is accepted in the same cycle.
// CONFIGURATION
//  - Macro BTU_ADDR_EXC_EN defined: out_addr_exc port exists.
//      It is 1 when out_target[SHIFT-1:0]!=0 (misaligned JR target, AdEL on fetch).
//      It is registered alongside out_target and is 0 for BR/J by construction.
//  - Macro undefined: the port and its logic are absent. A misaligned JR target passes through unchanged.
// STRUCTURE
//  - defines.vh (shared): `BTU_BR/`BTU_J/`BTU_JR mode codes, `BTU_MODE_W=2, `DATALENGTH.
//  - One sub-module, btu_stage: generic valid/ready pipeline register with flush, DATA_W-parametrised payload.
//      Instantiated PIPE_STAGES times.
//  - Target select and adders live in the top level.
// TESTING
//  - BR backward, PIPE_STAGES=2: pc=0xBFC00100, imm=0xFFFFFFFF
//      -> 2 cycles later out_target=0xBFC00100, out_fallthrough=0xBFC00104.
//  - J: pc=0x80000010, index=0x0100000 -> out_target=0x80400000.
//  - Wrap: BR pc=0xFFFFFFFC, imm=0x00000001 -> out_fallthrough=0x00000000, out_target=0x00000004.
//  - Backpressure: 4 back-to-back BRs, out_ready=0 for 5 cycles
//      -> in_ready=0 after 2 accepts, outputs stable.
//      Release -> 4 results in order, one per cycle, none lost or duplicated.
//  - Flush with 2 in flight plus a same-cycle input -> out_valid=0 next cycle.
//      Next accepted request emerges after PIPE_STAGES cycles.
//  - BTU_ADDR_EXC_EN: JR rs=0x80001003 -> out_target=0x80001003, out_addr_exc=1.
//      JR rs=0x80001000 -> out_addr_exc=0.

Source files
------------

// File: rtl/branch_target_unit_pkg.sv
// Shared definitions for the branch target unit: mode encoding and widths.
package branch_target_unit_pkg;

  localparam int unsigned DATALENGTH = 32;
  localparam int unsigned BTU_MODE_W = 2;

  // Redirect kinds produced by the decoder; 11 is reserved and falls through.
  typedef enum logic [BTU_MODE_W-1:0] {
    BTU_BR   = 2'b00,
    BTU_J    = 2'b01,
    BTU_JR   = 2'b10,
    BTU_RSVD = 2'b11
  } btu_mode_e;

endpackage

// File: rtl/btu_stage.sv
// Generic valid/ready pipeline register with flush and a DATA_W-wide payload.
// Loads whenever it is empty or its own content leaves this cycle.
module btu_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Room exists when the slot is empty or the consumer takes the current entry.
  assign ready_o = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Next state: flush empties the slot and drops the offered entry.
  always_comb begin
    // NOTE: defaults first so every path assigns each variable; otherwise a latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  // Slot register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking so every register in the chain samples pre-edge values.
    if (rst_i) begin
      valid_q <= 1'b0;
      // NOTE: payload is reset too so downstream outputs read 0, never X, after reset.
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/branch_target_unit.sv
// Pipelined branch/jump target generator for the fetch redirect path.
// Stage 1 registers the precomputed candidates; the target is selected from
// them, either registered in a second stage (PIPE_STAGES=2) or driven directly.
// Optional feature: define BTU_ADDR_EXC_EN to add out_addr_exc, flagging a
// target that is not instruction-aligned.
module branch_target_unit
  import branch_target_unit_pkg::*;
#(
  parameter int unsigned DATA_W      = DATALENGTH,
  parameter int unsigned SHIFT       = 2,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BTU_MODE_W-1:0] in_mode,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [DATA_W-7:0]     in_index,
  input  logic [DATA_W-1:0]     in_rs,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_target,
  output logic [DATA_W-1:0]     out_fallthrough
`ifdef BTU_ADDR_EXC_EN
  ,
  output logic                  out_addr_exc
`endif
);

  localparam int unsigned S1_W = BTU_MODE_W + 4 * DATA_W;
`ifdef BTU_ADDR_EXC_EN
  localparam int unsigned RES_W = 2 * DATA_W + 1;
`else
  localparam int unsigned RES_W = 2 * DATA_W;
`endif

  logic [DATA_W-1:0]     fall_in, off_in, region_in;
  logic [S1_W-1:0]       s1_in, s1_out;
  logic                  s1_valid, s1_ready;
  logic [BTU_MODE_W-1:0] s1_mode;
  logic [DATA_W-1:0]     s1_fall, s1_off, s1_region, s1_rs;
  logic [DATA_W-1:0]     sel_target;
  logic [RES_W-1:0]      res_d, res_out;

  // Candidates computed before stage 1; all sums wrap modulo 2^DATA_W.
  assign fall_in   = in_pc + DATA_W'(4);
  assign off_in    = in_imm << SHIFT;
  assign region_in = {fall_in[DATA_W-1:DATA_W-4], in_index, {SHIFT{1'b0}}};
  assign s1_in     = {in_mode, fall_in, off_in, region_in, in_rs};

  btu_stage #(.DATA_W(S1_W)) u_stage1 (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (flush),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  (s1_in),
    .valid_o (s1_valid),
    .ready_i (s1_ready),
    .data_o  (s1_out)
  );

  assign {s1_mode, s1_fall, s1_off, s1_region, s1_rs} = s1_out;

  // Target select from the stage-1 candidates; reserved mode falls through.
  always_comb begin
    sel_target = s1_fall;
    case (btu_mode_e'(s1_mode))
      BTU_BR:  sel_target = s1_fall + s1_off;
      BTU_J:   sel_target = s1_region;
      BTU_JR:  sel_target = s1_rs;
      default: sel_target = s1_fall;
    endcase
  end

`ifdef BTU_ADDR_EXC_EN
  assign res_d = {sel_target, s1_fall, |sel_target[SHIFT-1:0]};
  assign {out_target, out_fallthrough, out_addr_exc} = res_out;
`else
  assign res_d = {sel_target, s1_fall};
  assign {out_target, out_fallthrough} = res_out;
`endif

  if (PIPE_STAGES == 2) begin : g_two
    logic [RES_W-1:0] res_q;

    btu_stage #(.DATA_W(RES_W)) u_stage2 (
      .clk_i   (clock),
      .rst_i   (reset),
      .flush_i (flush),
      .valid_i (s1_valid),
      .ready_o (s1_ready),
      .data_i  (res_d),
      .valid_o (out_valid),
      .ready_i (out_ready),
      .data_o  (res_q)
    );

    assign res_out = res_q;
  end else begin : g_one
    assign s1_ready  = out_ready;
    assign out_valid = s1_valid;
    assign res_out   = res_d;
  end

endmodule

// File: tb/tb_branch_target_unit.sv
// Self-checking bench for branch_target_unit (default PIPE_STAGES=2).
// Table-driven single requests plus hand-written backpressure, flush and
// reset sequences. Build with BTU_ADDR_EXC_EN to also check out_addr_exc.
module tb_branch_target_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PIPE   = 2;
  localparam int unsigned NVEC   = 8;

  logic              clock = 1'b0;
  logic              reset, flush, in_valid, in_ready;
  logic [1:0]        in_mode;
  logic [DATA_W-1:0] in_pc, in_imm, in_rs;
  logic [DATA_W-7:0] in_index;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_target, out_fallthrough;
`ifdef BTU_ADDR_EXC_EN
  logic              out_addr_exc;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]        mode;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-7:0] index;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] exp_target;
    logic [DATA_W-1:0] exp_fall;
  } vec_t;

  vec_t vecs [NVEC];

  branch_target_unit #(.DATA_W(DATA_W), .SHIFT(2), .PIPE_STAGES(PIPE)) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_mode         (in_mode),
    .in_pc           (in_pc),
    .in_imm          (in_imm),
    .in_index        (in_index),
    .in_rs           (in_rs),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_target      (out_target),
    .out_fallthrough (out_fallthrough)
`ifdef BTU_ADDR_EXC_EN
    ,
    .out_addr_exc    (out_addr_exc)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_mode  = v.mode;
    in_pc    = v.pc;
    in_imm   = v.imm;
    in_index = v.index;
    in_rs    = v.rs;
  endtask

  // One request into an idle pipeline; checks acceptance, latency and result.
  task automatic send_one(input vec_t v, input int id);
    int n;
    @(negedge clock);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check($sformatf("v%0d_in_ready", id), 64'(in_ready), 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("v%0d_latency", id), 64'(n), 64'(PIPE));
    check($sformatf("v%0d_target", id), 64'(out_target), 64'(v.exp_target));
    check($sformatf("v%0d_fall", id), 64'(out_fallthrough), 64'(v.exp_fall));
`ifdef BTU_ADDR_EXC_EN
    check($sformatf("v%0d_exc", id), 64'(out_addr_exc), 64'(v.exp_target[1:0] != 2'b00));
`endif
  endtask

  initial begin
    vec_t bp [4];
    vec_t va, vb;
    int   next_in, next_out, first_out, last_out;
    logic acc;

    //           mode   pc            imm           index         rs            target        fall
    vecs[0] = '{2'b00, 32'hBFC00100, 32'hFFFFFFFF, 26'h0,        32'h0,        32'hBFC00100, 32'hBFC00104};
    vecs[1] = '{2'b01, 32'h80000010, 32'h0,        26'h0100000,  32'h0,        32'h80400000, 32'h80000014};
    vecs[2] = '{2'b00, 32'hFFFFFFFC, 32'h00000001, 26'h0,        32'h0,        32'h00000004, 32'h00000000};
    vecs[3] = '{2'b10, 32'h00400000, 32'h0,        26'h0,        32'h80001003, 32'h80001003, 32'h00400004};
    vecs[4] = '{2'b11, 32'h00400020, 32'h00000010, 26'h3FFFFFF,  32'h12345678, 32'h00400024, 32'h00400024};
    vecs[5] = '{2'b00, 32'h00400000, 32'h00000010, 26'h0,        32'h0,        32'h00400044, 32'h00400004};
    vecs[6] = '{2'b01, 32'h1FFFFFFC, 32'h0,        26'h0000001,  32'h0,        32'h20000004, 32'h20000000};
    vecs[7] = '{2'b10, 32'h00000000, 32'h0,        26'h0,        32'h80001000, 32'h80001000, 32'h00000004};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_target", 64'(out_target), 64'd0);
    check("rst_fall", 64'(out_fallthrough), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef BTU_ADDR_EXC_EN
    check("rst_exc", 64'(out_addr_exc), 64'd0);
`endif

    for (int i = 0; i < NVEC; i++) send_one(vecs[i], i);

    // Backpressure: four back-to-back BRs, consumer stalled for 5 cycles.
    for (int k = 0; k < 4; k++) begin
      bp[k] = '{2'b00, DATA_W'(32'h1000 * (k + 1)), DATA_W'(k + 1), 26'h0, 32'h0,
                DATA_W'(32'h1000 * (k + 1) + 4 + 4 * (k + 1)), DATA_W'(32'h1000 * (k + 1) + 4)};
    end
    next_in = 0; next_out = 0; first_out = -1; last_out = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      out_ready = (c >= 5);
      if (next_in < 4) begin
        drive(bp[next_in]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 2 && c <= 4) begin
        check($sformatf("bp_full_in_ready_c%0d", c), 64'(in_ready), 64'd0);
        check($sformatf("bp_accepts_c%0d", c), 64'(next_in), 64'd2);
        check($sformatf("bp_hold_target_c%0d", c), 64'(out_target), 64'(bp[0].exp_target));
        check($sformatf("bp_hold_fall_c%0d", c), 64'(out_fallthrough), 64'(bp[0].exp_fall));
      end
      if (c == 5) check("bp_full_drain_in_ready", 64'(in_ready), 64'd1);
      if (out_valid && out_ready) begin
        if (next_out < 4) begin
          check($sformatf("bp_order_target_%0d", next_out), 64'(out_target), 64'(bp[next_out].exp_target));
        end else begin
          check("bp_extra_output", 64'(next_out), 64'd3);
        end
        if (first_out < 0) first_out = c;
        last_out = c;
        next_out++;
      end
      acc = in_valid & in_ready;
      if (acc) next_in++;
    end
    check("bp_outputs_count", 64'(next_out), 64'd4);
    check("bp_one_per_cycle", 64'(last_out - first_out), 64'd3);

    // Flush with two in flight plus a same-cycle acceptable input.
    va = vecs[0]; vb = vecs[1];
    @(negedge clock);
    out_ready = 1'b0; drive(va); in_valid = 1'b1;
    @(negedge clock);
    drive(vb);
    @(negedge clock);
    drive(vecs[5]); out_ready = 1'b1; flush = 1'b1;
    #1;
    check("flush_pre_out_valid", 64'(out_valid), 64'd1);
    check("flush_same_cycle_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid_next", 64'(out_valid), 64'd0);
    repeat (3) @(negedge clock);
    check("flush_input_dropped", 64'(out_valid), 64'd0);
    send_one(vecs[6], 100);

    // Reset mid-operation: like flush, and data returns to 0.
    @(negedge clock);
    out_ready = 1'b0; drive(vecs[3]); in_valid = 1'b1;
    @(negedge clock);
    drive(vecs[5]);
    @(negedge clock);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_target", 64'(out_target), 64'd0);
    check("midrst_fall", 64'(out_fallthrough), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    send_one(vecs[2], 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
